// File: rtl/multicore_stream_hub_pkg.sv
// Shared defaults and the result-FIFO entry type for the multicore stream hub.
package multicore_pkg;
    localparam int DW      = 31;
    localparam int N_CORES = 28;
    localparam int DEPTH   = 16;
    localparam int SW      = $clog2(N_CORES);

    typedef struct packed {
        logic [SW-1:0] src;
        logic [DW-1:0] data;
    } hub_entry_t;
endpackage

// File: rtl/multicore_stream_hub_if.sv
// Bus bundle between the hub (master side) and the sample source, cores and result sink (slave side).
interface multicore_stream_hub_if #(
    parameter int DW      = multicore_pkg::DW,
    parameter int N_CORES = multicore_pkg::N_CORES,
    parameter int DEPTH   = multicore_pkg::DEPTH
);
    localparam int SW = $clog2(N_CORES);
    localparam int LW = $clog2(DEPTH) + 1;

    // Data fields carry two's-complement values; the hub never does arithmetic on them.
    logic [DW-1:0]         in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [N_CORES-1:0]    req_in;
    logic [DW-1:0]         core_in_data;
    logic [N_CORES-1:0]    core_in_valid;
    logic [N_CORES*DW-1:0] io_out;
    logic [N_CORES-1:0]    out_en;
    logic [N_CORES-1:0]    out_ack;
    logic [DW-1:0]         out_data;
    logic [SW-1:0]         out_src;
    logic                  out_valid;
    logic                  out_ready;
    logic [LW-1:0]         fifo_level;

    modport master (
        input  in_data, in_valid, req_in, io_out, out_en, out_ready,
        output in_ready, core_in_data, core_in_valid, out_ack,
               out_data, out_src, out_valid, fifo_level
    );

    modport slave (
        output in_data, in_valid, req_in, io_out, out_en, out_ready,
        input  in_ready, core_in_data, core_in_valid, out_ack,
               out_data, out_src, out_valid, fifo_level
    );
endinterface

// File: rtl/multicore_stream_hub_rr_arbiter.sv
// Round-robin picker: first set request at or after i_ptr, wrapping to index 0.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    logic w_hit;

    // Two passes: indices at/after the pointer first, then the wrapped-around low indices.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_hit && i_req[k] && (IW'(k) >= i_ptr)) begin
                w_hit      = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = IW'(k);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!w_hit && i_req[k]) begin
                w_hit      = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = IW'(k);
            end
        end
    end

    assign o_any = |i_req;
endmodule

// File: rtl/multicore_stream_hub.sv
// Sample dispatch to N cores and round-robin merge of core results through an ordered output FIFO.
module multicore_stream_hub #(
    parameter int DW      = multicore_pkg::DW,
    parameter int N_CORES = multicore_pkg::N_CORES,
    parameter int DEPTH   = multicore_pkg::DEPTH
) (
    input logic                    clk,
    input logic                    rst_n,
    multicore_stream_hub_if.master bus
);
    localparam int SW = $clog2(N_CORES);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [SW-1:0] src;
        logic [DW-1:0] data;
    } entry_t;

    logic [N_CORES-1:0] w_d_grant, w_c_grant;
    logic [SW-1:0]      w_d_idx, w_c_idx;
    logic               w_d_any, w_c_any;
    logic               w_in_hs, w_push, w_pop;
    logic [DW-1:0]      w_c_data;

    logic [SW-1:0]      r_in_ptr, r_out_ptr;
    logic [N_CORES-1:0] r_core_in_valid;
    logic [DW-1:0]      r_core_in_data;
    entry_t             r_mem [DEPTH];
    logic [AW-1:0]      r_wr, r_rd;
    logic [LW-1:0]      r_level;

    function automatic logic [SW-1:0] f_next(input logic [SW-1:0] i);
        return (i == SW'(N_CORES - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_arbiter #(.N(N_CORES)) u_disp (
        .i_req(bus.req_in), .i_ptr(r_in_ptr),
        .o_grant(w_d_grant), .o_idx(w_d_idx), .o_any(w_d_any)
    );

    rr_arbiter #(.N(N_CORES)) u_coll (
        .i_req(bus.out_en), .i_ptr(r_out_ptr),
        .o_grant(w_c_grant), .o_idx(w_c_idx), .o_any(w_c_any)
    );

    assign bus.in_ready = w_d_any;
    assign w_in_hs      = bus.in_valid && w_d_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_in_valid <= '0;
            r_core_in_data  <= '0;
            r_in_ptr        <= '0;
        end else if (w_in_hs) begin
            r_core_in_valid <= w_d_grant;
            r_core_in_data  <= bus.in_data;
            r_in_ptr        <= f_next(w_d_idx);
        end else begin
            r_core_in_valid <= '0;
        end
    end

    assign bus.core_in_valid = r_core_in_valid;
    assign bus.core_in_data  = r_core_in_data;

    // Full is judged on the registered level, so a same-cycle pop cannot open a slot.
    assign w_push      = rst_n && w_c_any && (r_level != LW'(DEPTH));
    assign w_pop       = (r_level != '0) && bus.out_ready;
    assign bus.out_ack = w_push ? w_c_grant : '0;

    always_comb begin
        w_c_data = '0;
        for (int k = 0; k < N_CORES; k++) begin
            if (w_c_grant[k]) w_c_data = w_c_data | bus.io_out[k*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr      <= '0;
            r_rd      <= '0;
            r_level   <= '0;
            r_out_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= '{src: w_c_idx, data: w_c_data};
                r_wr        <= r_wr + 1'b1;
                r_out_ptr   <= f_next(w_c_idx);
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign bus.out_valid  = (r_level != '0);
    assign bus.out_data   = r_mem[r_rd].data;
    assign bus.out_src    = r_mem[r_rd].src;
    assign bus.fifo_level = r_level;
endmodule
